// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle motion engine.
package paddle_pkg;

  localparam int SCREEN_LINES  = 480;
  localparam int PADDLE_HEIGHT = 80;
  localparam int Y_W           = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/paddle_motion_engine_if.sv
// Command/status bundle between the paddle controller and the motion engine.
interface paddle_motion_engine_if;
  import paddle_pkg::*;

  logic           delay;
  logic           moveUp;
  logic           moveDown;
  logic           done;
  logic [Y_W-1:0] paddleY;
  logic           atTop;
  logic           atBottom;

  modport master (
    output delay, moveUp, moveDown,
    input  done, paddleY, atTop, atBottom
  );

  modport slave (
    input  delay, moveUp, moveDown,
    output done, paddleY, atTop, atBottom
  );
endinterface

// File: rtl/paddle_delay_timer.sv
// Delay-interval timer: accepts a delay request and pulses done once the
// interval has elapsed. Requests seen while counting are ignored.
// Build option: PADDLE_FAST_SIM_EN shortens the interval to 16 cycles.
//
//   state | meaning
//   IDLE  | waiting for a delay request
//   COUNT | interval running, counter 0 .. length-1
//   FIRE  | done high for this one cycle; a pending request restarts at once
module paddle_delay_timer
  import paddle_pkg::*;
#(
  parameter int DELAY_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic delay,
  output logic done
);

`ifdef PADDLE_FAST_SIM_EN
  localparam int EFF_CYCLES = 16;
`else
  localparam int EFF_CYCLES = DELAY_CYCLES;
`endif

  localparam int            CW   = $clog2(EFF_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(EFF_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_COUNT = COUNT;
  localparam logic [1:0] ST_FIRE  = FIRE;

  logic [1:0]    state;
  logic [CW-1:0] count;

  // State and interval counter advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (delay) begin
            state <= ST_COUNT;
            count <= '0;
          end
        end
        ST_COUNT: begin
          if (count == LAST) state <= ST_FIRE;
          else               count <= count + CW'(1);
        end
        ST_FIRE: begin
          if (delay) begin
            state <= ST_COUNT;
            count <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done = (state == ST_FIRE);

endmodule

// File: rtl/paddle_motion_engine.sv
// Paddle motion engine: clamped paddle position plus the delay timer used
// to pace the controller.
// Build option: PADDLE_FAST_SIM_EN (see paddle_delay_timer) shortens delays.
module paddle_motion_engine
  import paddle_pkg::*;
#(
  parameter int DELAY_CYCLES = 1000000,
  parameter int STEP         = 4,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = SCREEN_LINES - PADDLE_HEIGHT,
  parameter int Y_RESET      = 200
) (
  input  logic                   CLK_100MHz,
  input  logic                   Reset,
  paddle_motion_engine_if.slave  bus
);

  localparam logic [10:0]    MIN11  = 11'(Y_MIN);
  localparam logic [10:0]    MAX11  = 11'(Y_MAX);
  localparam logic [10:0]    STEP11 = 11'(STEP);
  localparam logic [Y_W-1:0] YMIN   = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] YMAX   = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] YRST   = Y_W'(Y_RESET);

  paddle_delay_timer #(
    .DELAY_CYCLES (DELAY_CYCLES)
  ) u_timer (
    .clk   (CLK_100MHz),
    .rst   (Reset),
    .delay (bus.delay),
    .done  (bus.done)
  );

  logic [10:0]    y_ext;
  logic [10:0]    y_dn_sum;
  logic [10:0]    y_up_diff;
  logic [Y_W-1:0] next_y;

  assign y_ext     = {1'b0, bus.paddleY};
  assign y_dn_sum  = y_ext + STEP11;
  assign y_up_diff = y_ext - STEP11;

  // Next position, clamped; the up path compares before subtracting so it
  // can never wrap below Y_MIN.
  always_comb begin
    next_y = bus.paddleY;
    if (bus.moveUp && !bus.moveDown) begin
      if (y_ext < MIN11 + STEP11) next_y = YMIN;
      else                        next_y = y_up_diff[Y_W-1:0];
    end else if (bus.moveDown && !bus.moveUp) begin
      if (y_dn_sum > MAX11) next_y = YMAX;
      else                  next_y = y_dn_sum[Y_W-1:0];
    end
  end

  // Position and edge flags register together so they always agree.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      bus.paddleY  <= YRST;
      bus.atTop    <= (YRST == YMIN);
      bus.atBottom <= (YRST == YMAX);
    end else begin
      bus.paddleY  <= next_y;
      bus.atTop    <= (next_y == YMIN);
      bus.atBottom <= (next_y == YMAX);
    end
  end

endmodule

// File: tb/tb_paddle_motion_engine.sv
// Directed bench for paddle_motion_engine. Both instances use a 16-cycle
// delay, which matches the PADDLE_FAST_SIM_EN length either way.
module tb_paddle_motion_engine;
  import paddle_pkg::*;

  localparam int D = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  paddle_motion_engine_if if_a ();
  paddle_motion_engine_if if_b ();

  paddle_motion_engine #(.DELAY_CYCLES(D)) dut_a (
    .CLK_100MHz (clk),
    .Reset      (rst),
    .bus        (if_a.slave)
  );

  paddle_motion_engine #(.DELAY_CYCLES(D), .Y_RESET(398)) dut_b (
    .CLK_100MHz (clk),
    .Reset      (rst),
    .bus        (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       down;
    int         y;
    logic       top;
    logic       bot;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    if_a.delay = 0; if_a.moveUp = 0; if_a.moveDown = 0;
    if_b.delay = 0; if_b.moveUp = 0; if_b.moveDown = 0;

    tbl[0] = '{0, 1, 400, 0, 1};
    tbl[1] = '{0, 1, 400, 0, 1};
    tbl[2] = '{1, 1, 400, 0, 1};
    tbl[3] = '{1, 0, 396, 0, 0};
    tbl[4] = '{1, 0, 392, 0, 0};
    tbl[5] = '{0, 0, 392, 0, 0};
    tbl[6] = '{0, 1, 396, 0, 0};
    tbl[7] = '{0, 1, 400, 0, 1};
    tbl[8] = '{1, 1, 400, 0, 1};
    tbl[9] = '{1, 0, 396, 0, 0};

    // Reset state
    @(negedge clk);
    do_reset(2);
    check("rst_y_a", int'(if_a.paddleY), 200);
    check("rst_top_a", int'(if_a.atTop), 0);
    check("rst_bot_a", int'(if_a.atBottom), 0);
    check("rst_done_a", int'(if_a.done), 0);
    check("rst_y_b", int'(if_b.paddleY), 398);
    check("rst_bot_b", int'(if_b.atBottom), 0);

    // Single delay pulse: done only on the 16th edge after the sampling edge
    if_a.delay = 1'b1;
    tick();
    if_a.delay = 1'b0;
    check("pulse_done0", int'(if_a.done), 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("pulse_done", int'(if_a.done), (i == D) ? 1 : 0);
      check("pulse_y", int'(if_a.paddleY), 200);
    end

    // Held delay: back-to-back intervals, period D+1
    if_a.delay = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("held_done", int'(if_a.done), (i % (D + 1) == D) ? 1 : 0);
    end
    if_a.delay = 1'b0;
    do_reset(2);

    // Move up from 200 until clamped at 0
    if_a.moveUp = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      int exp_y;
      tick();
      exp_y = (200 - 4 * k < 0) ? 0 : 200 - 4 * k;
      check("up_y", int'(if_a.paddleY), exp_y);
      check("up_top", int'(if_a.atTop), (exp_y == 0) ? 1 : 0);
      check("up_bot", int'(if_a.atBottom), 0);
    end
    if_a.moveUp = 1'b0;

    // Table: instance starting at 398 near the bottom clamp
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      if_b.moveUp   = tbl[i].up;
      if_b.moveDown = tbl[i].down;
      tick();
      check("tbl_y", int'(if_b.paddleY), tbl[i].y);
      check("tbl_top", int'(if_b.atTop), int'(tbl[i].top));
      check("tbl_bot", int'(if_b.atBottom), int'(tbl[i].bot));
    end
    if_b.moveUp = 0; if_b.moveDown = 0;

    // Both commands high: no motion
    do_reset(1);
    if_a.moveUp = 1'b1; if_a.moveDown = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("both_y", int'(if_a.paddleY), 200);
    end
    if_a.moveDown = 1'b0;

    // Reset on the 8th COUNT cycle aborts the interval
    if_a.moveUp = 1'b0;
    if_a.delay = 1'b1;
    tick();
    if_a.delay = 1'b0;
    if_a.moveUp = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("abort_pre_done", int'(if_a.done), 0);
    end
    if_a.moveUp = 1'b0;
    check("abort_pre_y", int'(if_a.paddleY), 172);
    do_reset(1);
    check("abort_rst_y", int'(if_a.paddleY), 200);
    for (int i = 0; i < 25; i++) begin
      tick();
      check("abort_done", int'(if_a.done), 0);
    end
    check("abort_y", int'(if_a.paddleY), 200);

    // Delay held through reset release starts on the first post-reset edge
    rst = 1'b1;
    if_a.delay = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    if_a.delay = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("rel_done", int'(if_a.done), (i == D) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
